// File: rtl/pmem_pkg.sv
// Shared types and byte-lane helpers for the pmem responder.
// The helpers move the core's LSB-aligned store/load data onto the addressed byte lanes.
package pmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } pmem_state_e;

   localparam logic [31:0] PMEM_BASE_ADDR = 32'h8000_0000;

   // Lanes shifted past byte 3 fall off; there is no cross-word access.
   function automatic logic [3:0] shift_wmask(input logic [3:0] mask, input logic [1:0] off);
      return mask << off;
   endfunction

   function automatic logic [31:0] shift_wdata(input logic [31:0] data, input logic [1:0] off);
      return data << {off, 3'b000};
   endfunction

   // Zero-filled from the top; sign extension is left to the core.
   function automatic logic [31:0] shift_rdata(input logic [31:0] data, input logic [1:0] off);
      return data >> {off, 3'b000};
   endfunction

endpackage

// File: rtl/pmem_sram_array.sv
// Word array with per-byte write enables and an asynchronous read port.
// Contents are never reset.
module pmem_sram_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wmask,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the core's load/store port: one outstanding request,
// byte-masked writes and a fixed response latency against an on-chip word array.
module pmem_responder
   import pmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = PMEM_BASE_ADDR,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW      = $clog2(DEPTH_WORDS);
   localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
   localparam int CW      = ($clog2(LATENCY + 1) < 1) ? 1 : $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT_EFF);
   localparam logic [32:0]   SPAN     = 33'(DEPTH_WORDS) << 2;

   pmem_state_e state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic accept, lat_done, rsp_done;

   logic [31:0] rel_addr;
   logic        in_range;

   logic          wen_p0;
   logic [AW-1:0] idx_p0;
   logic [1:0]    off_p0;
   logic [31:0]   wdata_p0;
   logic [3:0]    wmask_p0;
   logic          err_p0;

   logic        sram_we;
   logic [31:0] sram_rdata;

   // Unsigned compare of the offset catches addresses both below and above the window.
   assign rel_addr = req_addr - BASE_ADDR;
   assign in_range = (req_addr >= BASE_ADDR) && ({1'b0, rel_addr} < SPAN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      lat_done  = 1'b0;
      rsp_done  = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               lat_done = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p0: request captured at the handshake, already lane-aligned.
   always_ff @(posedge clk) begin
      if (accept) begin
         wen_p0   <= req_wen;
         idx_p0   <= rel_addr[AW+1:2];
         off_p0   <= req_addr[1:0];
         wdata_p0 <= shift_wdata(req_wdata, req_addr[1:0]);
         wmask_p0 <= shift_wmask(req_wmask, req_addr[1:0]);
         err_p0   <= ~in_range;
      end
   end

   // Stage p1: latency count, array access and the held response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q <= CW'(1);
         end else if (lat_done) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (lat_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_p0;
            rsp_rdata <= (wen_p0 || err_p0) ? '0 : shift_rdata(sram_rdata, off_p0);
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Writes land on the same edge the response becomes valid, so a reset before then drops them.
   assign sram_we = lat_done && wen_p0 && !err_p0;

   pmem_sram_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .ADDR_W     (AW)
   ) u_array (
      .clk  (clk),
      .we   (sram_we),
      .waddr(idx_p0),
      .wdata(wdata_p0),
      .wmask(wmask_p0),
      .raddr(idx_p0),
      .rdata(sram_rdata)
   );

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: three instances at LATENCY 2, 0 and 5
// share request inputs; only the selected instance sees req_valid.
module tb_pmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  req_valid_v;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        rsp_ready;

   logic [2:0]  rdy_v;
   logic [2:0]  vld_v;
   logic [2:0]  err_v;
   logic [31:0] rdat_a [3];

   int checks = 0;
   int errors = 0;
   int sel    = 0;

   pmem_responder #(.LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(rdy_v[0]),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(vld_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdat_a[0]), .rsp_err(err_v[0])
   );

   pmem_responder #(.LATENCY(0)) u_lat0 (
      .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(rdy_v[1]),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(vld_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdat_a[1]), .rsp_err(err_v[1])
   );

   pmem_responder #(.LATENCY(5)) u_lat5 (
      .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_ready(rdy_v[2]),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(vld_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdat_a[2]), .rsp_err(err_v[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the selected instance idle; returns #1 after
   // the edge on which the response is consumed (rsp_ready must be high).
   task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int lat;
      chk1({tag, "_ready_idle"}, rdy_v[sel], 1'b1);
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = mask;
      req_valid_v      = 3'b000;
      req_valid_v[sel] = 1'b1;
      @(posedge clk); #1;
      req_valid_v = 3'b000;
      chk1({tag, "_ready_wait"}, rdy_v[sel], 1'b0);
      lat = 0;
      while (!vld_v[sel] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_rdata"}, rdat_a[sel], exp_rdata);
      chk1({tag, "_err"}, err_v[sel], exp_err);
      chk1({tag, "_ready_resp"}, rdy_v[sel], 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic reset_midop(input string tag, input int d, input int cyc);
      sel       = d;
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0000;
      req_wdata = 32'h0000_0055;
      req_wmask = 4'b1111;
      req_valid_v    = 3'b000;
      req_valid_v[d] = 1'b1;
      @(posedge clk); #1;
      req_valid_v = 3'b000;
      repeat (cyc) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      chk1({tag, "_rst_ready"}, rdy_v[d], 1'b1);
      chk1({tag, "_rst_valid"}, vld_v[d], 1'b0);
      chk({tag, "_rst_rdata"}, rdat_a[d], 32'h0);
      chk1({tag, "_rst_err"}, err_v[d], 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      req_valid_v = 3'b000;
      req_wen     = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_wmask   = '0;
      rsp_ready   = 1'b1;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk1("reset_ready", rdy_v[i], 1'b1);
         chk1("reset_valid", vld_v[i], 1'b0);
         chk("reset_rdata", rdat_a[i], 32'h0);
         chk1("reset_err", err_v[i], 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Word write then read back, LATENCY=2
      sel = 0;
      txn("sw10", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 2);
      txn("lw10", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 2);
      txn("sw00", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 2);

      // Byte write and byte-offset reads
      txn("sw20", 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 2);
      txn("sb22", 1'b1, 32'h8000_0022, 32'h0000_00AB, 4'b0001, 32'h0, 1'b0, 2);
      txn("lw20", 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 32'h11AB_3344, 1'b0, 2);
      txn("lb22", 1'b0, 32'h8000_0022, 32'h0, 4'b0000, 32'h0000_11AB, 1'b0, 2);
      txn("lb21", 1'b0, 32'h8000_0021, 32'h0, 4'b0000, 32'h0011_AB33, 1'b0, 2);

      // Half writes, including the truncated one at offset 3, and an empty mask
      txn("sw04", 1'b1, 32'h8000_0004, 32'h0102_0304, 4'b1111, 32'h0, 1'b0, 2);
      txn("sh06", 1'b1, 32'h8000_0006, 32'h0000_BEEF, 4'b0011, 32'h0, 1'b0, 2);
      txn("lw04a", 1'b0, 32'h8000_0004, 32'h0, 4'b0000, 32'hBEEF_0304, 1'b0, 2);
      txn("sh07", 1'b1, 32'h8000_0007, 32'h0000_CAFE, 4'b0011, 32'h0, 1'b0, 2);
      txn("lw04b", 1'b0, 32'h8000_0004, 32'h0, 4'b0000, 32'hFEEF_0304, 1'b0, 2);
      txn("sw04m0", 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 2);
      txn("lw04c", 1'b0, 32'h8000_0004, 32'h0, 4'b0000, 32'hFEEF_0304, 1'b0, 2);

      // Out-of-range accesses
      txn("lw_low", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 32'h0, 1'b1, 2);
      txn("sw_high", 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b1, 2);
      txn("lw00a", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 2);

      // Response backpressure with stray requests during the stall
      rsp_ready   = 1'b0;
      req_wen     = 1'b0;
      req_addr    = 32'h8000_0010;
      req_valid_v = 3'b001;
      @(posedge clk); #1;
      req_valid_v = 3'b000;
      begin
         int n;
         n = 0;
         while (!vld_v[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         chk("bp_lat", n, 2);
      end
      chk("bp_rdata", rdat_a[0], 32'hDEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
         req_wen     = 1'b1;
         req_addr    = 32'h8000_0010;
         req_wdata   = 32'h0;
         req_wmask   = 4'b1111;
         req_valid_v = 3'b001;
         @(posedge clk); #1;
         chk1("bp_valid_hold", vld_v[0], 1'b1);
         chk("bp_rdata_hold", rdat_a[0], 32'hDEAD_BEEF);
         chk1("bp_err_hold", err_v[0], 1'b0);
         chk1("bp_ready_low", rdy_v[0], 1'b0);
      end
      req_valid_v = 3'b000;
      rsp_ready   = 1'b1;
      @(posedge clk); #1;
      chk1("bp_release_valid", vld_v[0], 1'b0);
      chk1("bp_release_ready", rdy_v[0], 1'b1);
      txn("bp_after", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 2);

      // LATENCY=0 behaves as 1 cycle, LATENCY=5 as 5
      sel = 1;
      txn("l0_sw00", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1);
      txn("l0_lw00", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 1);
      sel = 2;
      txn("l5_sw00", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 5);
      txn("l5_lw00", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 5);

      // Reset before the write commits: the store is lost, old data persists
      reset_midop("l2", 0, 1);
      sel = 0;
      txn("l2_post", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 2);
      reset_midop("l0", 1, 0);
      sel = 1;
      txn("l0_post", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 1);
      reset_midop("l5", 2, 1);
      sel = 2;
      txn("l5_post", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
